// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with one-cycle grant, transaction tracking and watchdog abort.
module bus_arbiter #(
  parameter int NR_MASTERS    = 4,
  parameter int BEGIN_TIMEOUT = 16,
  parameter int BUS_TIMEOUT   = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NR_MASTERS-1:0] busRequests,
  output logic [NR_MASTERS-1:0] busGrants,
  input  logic                  beginTransactionIn,
  input  logic                  endTransactionIn,
  input  logic                  dataValidIn,
  input  logic                  busErrorIn,
  output logic                  busErrorOut,
  output logic                  endTransactionOut,
  output logic [3:0]            activeMaster,
  output logic                  busBusy
);
  localparam int MAX_T = BEGIN_TIMEOUT > BUS_TIMEOUT ? BEGIN_TIMEOUT : BUS_TIMEOUT;
  localparam int CW = $clog2(MAX_T) + 1;
  typedef enum logic [2:0] {IDLE, GRANT, WAIT_BEGIN, BUSY, ABORT} state_t;
  state_t state;
  logic [CW-1:0] cnt, cnt_inc;
  logic [3:0] pick;
  logic found;
  logic [4:0] idx;
  logic [NR_MASTERS-1:0] sh;
  assign cnt_inc = &cnt ? cnt : cnt + CW'(1);
  // scan activeMaster+1, +2, ... so the last served master ends up with lowest priority
  always_comb begin
    pick = activeMaster;
    found = 1'b0;
    idx = '0;
    sh = '0;
    for (int k = 1; k <= NR_MASTERS; k++) begin
      idx = {1'b0, activeMaster} + 5'(k);
      idx = idx >= 5'(NR_MASTERS) ? idx - 5'(NR_MASTERS) : idx;
      sh = busRequests >> idx;
      if (!found && sh[0]) begin
        pick = idx[3:0];
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busGrants <= '0;
      busErrorOut <= 1'b0;
      endTransactionOut <= 1'b0;
      activeMaster <= 4'(NR_MASTERS - 1);
      busBusy <= 1'b0;
      cnt <= '0;
    end else begin
      busGrants <= '0;
      busErrorOut <= 1'b0;
      endTransactionOut <= 1'b0;
      case (state)
        IDLE: if (found) begin
          activeMaster <= pick;
          busGrants <= NR_MASTERS'(1) << pick;
          busBusy <= 1'b1;
          state <= GRANT;
        end
        GRANT: begin
          cnt <= '0;
          state <= WAIT_BEGIN;
        end
        WAIT_BEGIN: if (beginTransactionIn) begin
          cnt <= '0;
          state <= BUSY;
        end else if (cnt == CW'(BEGIN_TIMEOUT - 1)) begin
          busBusy <= 1'b0;
          state <= IDLE;
        end else cnt <= cnt_inc;
        // end/error beats the watchdog when both land in the same cycle
        BUSY: if (endTransactionIn || busErrorIn) begin
          busBusy <= 1'b0;
          state <= IDLE;
        end else if (dataValidIn) cnt <= '0;
        else if (cnt == CW'(BUS_TIMEOUT - 1)) begin
          busErrorOut <= 1'b1;
          endTransactionOut <= 1'b1;
          state <= ABORT;
        end else cnt <= cnt_inc;
        default: begin
          busBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter; expected grant indices are queued at stimulus time.
module tb_bus_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic [3:0] busRequests = '0, busGrants, activeMaster;
  logic beginTransactionIn = 1'b0, endTransactionIn = 1'b0, dataValidIn = 1'b0, busErrorIn = 1'b0;
  logic busErrorOut, endTransactionOut, busBusy;
  int checks = 0, errors = 0, abort_cnt = 0;
  int exp_q[$];

  bus_arbiter dut (
    .clock(clock), .reset(reset), .busRequests(busRequests), .busGrants(busGrants),
    .beginTransactionIn(beginTransactionIn), .endTransactionIn(endTransactionIn),
    .dataValidIn(dataValidIn), .busErrorIn(busErrorIn), .busErrorOut(busErrorOut),
    .endTransactionOut(endTransactionOut), .activeMaster(activeMaster), .busBusy(busBusy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every grant seen is compared against the oldest queued expectation
  always @(negedge clock) begin
    if (busGrants != 4'b0) begin
      if (exp_q.size() == 0) check("grant_unexpected", 32'(busGrants), 32'h0);
      else begin
        int e;
        e = exp_q.pop_front();
        check("grant_onehot", 32'(busGrants), 32'(1) << e);
        check("grant_active", 32'(activeMaster), 32'(e));
      end
    end
    if (busErrorOut) begin
      abort_cnt++;
      check("abort_pair", 32'(endTransactionOut), 32'h1);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    busRequests = '0;
    beginTransactionIn = 1'b0;
    endTransactionIn = 1'b0;
    dataValidIn = 1'b0;
    busErrorIn = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_grant();
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      got = busGrants != 4'b0;
    end
    if (!got) check("grant_timeout", 32'h0, 32'h1);
  endtask

  // grant -> begin one cycle later -> end one cycle after that
  task automatic txn(input int exp);
    exp_q.push_back(exp);
    wait_grant();
    @(negedge clock);
    beginTransactionIn = 1'b1;
    @(negedge clock);
    beginTransactionIn = 1'b0;
    check("busy_in_txn", 32'(busBusy), 32'h1);
    endTransactionIn = 1'b1;
    @(negedge clock);
    endTransactionIn = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_grants", 32'(busGrants), 32'h0);
    check("rst_busy", 32'(busBusy), 32'h0);
    check("rst_active", 32'(activeMaster), 32'h3);
    check("rst_err", 32'(busErrorOut), 32'h0);
    // single-cycle request from master 0
    @(negedge clock);
    busRequests = 4'b0001;
    exp_q.push_back(0);
    @(negedge clock);
    busRequests = '0;
    check("grant_latency", 32'(busGrants), 32'h1);
    @(negedge clock);
    check("grant_one_cycle", 32'(busGrants), 32'h0);
    repeat (20) @(negedge clock);
    check("idle_after_forfeit", 32'(busBusy), 32'h0);
    // round robin with all masters requesting
    do_reset();
    busRequests = 4'b1111;
    for (int m = 0; m < 5; m++) txn(m % 4);
    busRequests = '0;
    repeat (3) @(negedge clock);
    do_reset();
    repeat (20) @(negedge clock);
    // begin timeout after grant to master 2
    busRequests = 4'b0100;
    exp_q.push_back(2);
    wait_grant();
    busRequests = '0;
    repeat (16) @(negedge clock);
    check("wb_busy_at_15", 32'(busBusy), 32'h1);
    @(negedge clock);
    check("wb_idle_at_16", 32'(busBusy), 32'h0);
    check("wb_no_abort", 32'(abort_cnt), 32'h0);
    busRequests = 4'b0001;
    exp_q.push_back(0);
    wait_grant();
    busRequests = '0;
    repeat (20) @(negedge clock);
    // bus watchdog abort
    busRequests = 4'b0010;
    exp_q.push_back(1);
    wait_grant();
    busRequests = '0;
    @(negedge clock);
    beginTransactionIn = 1'b1;
    @(negedge clock);
    beginTransactionIn = 1'b0;
    dataValidIn = 1'b1;
    @(negedge clock);
    dataValidIn = 1'b0;
    repeat (1023) @(negedge clock);
    check("wd_pre_err", 32'(busErrorOut), 32'h0);
    check("wd_pre_busy", 32'(busBusy), 32'h1);
    @(negedge clock);
    check("wd_err", 32'(busErrorOut), 32'h1);
    check("wd_end", 32'(endTransactionOut), 32'h1);
    @(negedge clock);
    check("wd_err_clear", 32'(busErrorOut), 32'h0);
    check("wd_idle", 32'(busBusy), 32'h0);
    check("wd_abort_count", 32'(abort_cnt), 32'h1);
    // end coinciding with watchdog expiry
    busRequests = 4'b0100;
    exp_q.push_back(2);
    wait_grant();
    busRequests = '0;
    @(negedge clock);
    beginTransactionIn = 1'b1;
    @(negedge clock);
    beginTransactionIn = 1'b0;
    repeat (1023) @(negedge clock);
    endTransactionIn = 1'b1;
    @(negedge clock);
    endTransactionIn = 1'b0;
    check("tie_no_err", 32'(busErrorOut), 32'h0);
    check("tie_idle", 32'(busBusy), 32'h0);
    @(negedge clock);
    check("tie_abort_count", 32'(abort_cnt), 32'h1);
    // async reset during BUSY
    busRequests = 4'b1000;
    exp_q.push_back(3);
    wait_grant();
    busRequests = '0;
    @(negedge clock);
    beginTransactionIn = 1'b1;
    @(negedge clock);
    beginTransactionIn = 1'b0;
    @(negedge clock);
    check("pre_rst_busy", 32'(busBusy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(busBusy), 32'h0);
    check("async_rst_grants", 32'(busGrants), 32'h0);
    check("async_rst_active", 32'(activeMaster), 32'h3);
    @(negedge clock);
    reset = 1'b0;
    busRequests = 4'b1111;
    exp_q.push_back(0);
    wait_grant();
    busRequests = '0;
    repeat (20) @(negedge clock);
    check("sb_empty", 32'(exp_q.size()), 32'h0);
    check("final_abort_count", 32'(abort_cnt), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
